// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencer with one-entry skid buffer and redirect squash.
// Define FETCH_CTRL_PERF_EN to add the perf_fetched/perf_stall counters.
module fetch_ctrl #(
    parameter int                AWIDTH     = 15,
    parameter int                DWIDTH     = 32,
    parameter logic [AWIDTH-1:0] RESET_ADDR = '0,
    parameter logic [DWIDTH-1:0] NOP_INSTR  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_addr_i,
    output logic [AWIDTH-1:0] pmem_addr,
    output logic              pmem_rd,
    input  logic [DWIDTH-1:0] pmem_rdata,
    output logic [AWIDTH-1:0] fetch_addr,
    output logic [DWIDTH-1:0] fetch_instr,
    output logic              fetch_valid
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HELD = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [AWIDTH-1:0] r_pc;
    logic              r_inf_vld;
    logic [AWIDTH-1:0] r_inf_addr;
    logic              r_skid_vld;
    logic [AWIDTH-1:0] r_skid_addr;
    logic [DWIDTH-1:0] r_skid_instr;
    logic              w_redir;
    logic              w_issue;

    // Redirect is gated by reset so the memory port stays quiet while held in reset.
    assign w_redir = redirect_i & rst;
    assign w_issue = ~w_redir & ~stall_i & run_i & (r_state != IDLE);

    assign pmem_rd   = w_redir | w_issue;
    assign pmem_addr = w_redir ? redirect_addr_i : r_pc;

    always_comb begin
        w_state_nxt = r_state;
        if (w_redir) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                IDLE: begin
                    if (run_i) w_state_nxt = RUN;
                end
                RUN: begin
                    if (stall_i)     w_state_nxt = HELD;
                    else if (!run_i) w_state_nxt = IDLE;
                end
                HELD: begin
                    if (!stall_i) w_state_nxt = run_i ? RUN : IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        fetch_valid = 1'b0;
        fetch_addr  = '0;
        fetch_instr = NOP_INSTR;
        priority case (1'b1)
            w_redir: begin
                fetch_valid = 1'b0;
            end
            r_skid_vld: begin
                fetch_valid = 1'b1;
                fetch_addr  = r_skid_addr;
                fetch_instr = r_skid_instr;
            end
            r_inf_vld: begin
                fetch_valid = 1'b1;
                fetch_addr  = r_inf_addr;
                fetch_instr = pmem_rdata;
            end
            default: begin
                fetch_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_pc         <= RESET_ADDR;
            r_inf_vld    <= 1'b0;
            r_inf_addr   <= '0;
            r_skid_vld   <= 1'b0;
            r_skid_addr  <= '0;
            r_skid_instr <= NOP_INSTR;
        end else begin
            r_state <= w_state_nxt;
            if (w_redir) begin
                r_pc       <= redirect_addr_i + 1'b1;
                r_inf_vld  <= 1'b1;
                r_inf_addr <= redirect_addr_i;
                r_skid_vld <= 1'b0;
            end else begin
                r_inf_vld <= w_issue;
                if (w_issue) begin
                    r_pc       <= r_pc + 1'b1;
                    r_inf_addr <= r_pc;
                end
                // Park the returning read so the memory may drop it.
                if (stall_i && r_inf_vld) begin
                    r_skid_vld   <= 1'b1;
                    r_skid_addr  <= r_inf_addr;
                    r_skid_instr <= pmem_rdata;
                end else if (!stall_i) begin
                    r_skid_vld <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (fetch_valid && !stall_i) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (stall_i)                 r_perf_stall   <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus with a stream-level reference model.
// Second instance covers a RESET_ADDR near the top of the address space.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] BASE = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [14:0] redirect_addr_i = '0;
    logic [14:0] pmem_addr;
    logic        pmem_rd;
    logic [31:0] pmem_rdata = '0;
    logic [14:0] fetch_addr;
    logic [31:0] fetch_instr;
    logic        fetch_valid;

    logic        rst2 = 1'b0;
    logic [14:0] pmem_addr2;
    logic        pmem_rd2;
    logic [31:0] pmem_rdata2 = '0;
    logic [14:0] fetch_addr2;
    logic [31:0] fetch_instr2;
    logic        fetch_valid2;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_fetched2;
    logic [31:0] perf_stall2;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_ctrl u_dut (
        .clk             (clk),
        .rst             (rst),
        .run_i           (run_i),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .pmem_addr       (pmem_addr),
        .pmem_rd         (pmem_rd),
        .pmem_rdata      (pmem_rdata),
        .fetch_addr      (fetch_addr),
        .fetch_instr     (fetch_instr),
        .fetch_valid     (fetch_valid)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_stall      (perf_stall)
`endif
    );

    fetch_ctrl #(.RESET_ADDR(15'h7FFE)) u_dut2 (
        .clk             (clk),
        .rst             (rst2),
        .run_i           (1'b1),
        .stall_i         (1'b0),
        .redirect_i      (1'b0),
        .redirect_addr_i (15'h0000),
        .pmem_addr       (pmem_addr2),
        .pmem_rd         (pmem_rd2),
        .pmem_rdata      (pmem_rdata2),
        .fetch_addr      (fetch_addr2),
        .fetch_instr     (fetch_instr2),
        .fetch_valid     (fetch_valid2)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_fetched    (perf_fetched2),
        .perf_stall      (perf_stall2)
`endif
    );

    // Program memories: 1-cycle latency, data held when not reading
    always @(posedge clk) begin
        if (pmem_rd)  pmem_rdata  <= BASE + {17'd0, pmem_addr};
        if (pmem_rd2) pmem_rdata2 <= BASE + {17'd0, pmem_addr2};
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Stream model: what the front end must deliver, by address
    logic [14:0] m_exp_addr = '0;
    logic [14:0] m_exp_pc = '0;
    logic        m_prev_rd = 1'b0;
    logic        m_prev_vld = 1'b0;
    logic        m_prev_stall = 1'b0;
    logic        m_engaged = 1'b0;
    logic [31:0] m_fetched = '0;
    logic [31:0] m_stalls = '0;

    always @(negedge clk) begin
        logic exp_vld;
        if (!rst) begin
            chk("m_rst_vld", fetch_valid, 1'b0);
            chk("m_rst_addr", fetch_addr, 15'h0);
            chk("m_rst_instr", fetch_instr, NOP);
            chk("m_rst_rd", pmem_rd, 1'b0);
            chk("m_rst_paddr", pmem_addr, 15'h0);
`ifdef FETCH_CTRL_PERF_EN
            chk("m_rst_pf", perf_fetched, 32'd0);
            chk("m_rst_ps", perf_stall, 32'd0);
`endif
            m_exp_addr   = '0;
            m_exp_pc     = '0;
            m_prev_rd    = 1'b0;
            m_prev_vld   = 1'b0;
            m_prev_stall = 1'b0;
            m_engaged    = 1'b0;
            m_fetched    = '0;
            m_stalls     = '0;
        end else begin
`ifdef FETCH_CTRL_PERF_EN
            chk("m_perf_fetched", perf_fetched, m_fetched);
            chk("m_perf_stall", perf_stall, m_stalls);
`endif
            if (fetch_valid && !stall_i) m_fetched = m_fetched + 1;
            if (stall_i) m_stalls = m_stalls + 1;
            if (redirect_i) begin
                chk("m_redir_vld", fetch_valid, 1'b0);
                chk("m_redir_instr", fetch_instr, NOP);
                chk("m_redir_rd", pmem_rd, 1'b1);
                chk("m_redir_paddr", pmem_addr, redirect_addr_i);
                m_exp_addr = redirect_addr_i;
                m_exp_pc   = redirect_addr_i + 15'd1;
            end else begin
                exp_vld = m_prev_rd | (m_prev_vld & m_prev_stall);
                chk("m_vld", fetch_valid, exp_vld);
                if (fetch_valid) begin
                    chk("m_addr", fetch_addr, m_exp_addr);
                    chk("m_instr", fetch_instr, BASE + {17'd0, fetch_addr});
                    if (!stall_i) m_exp_addr = m_exp_addr + 15'd1;
                end else begin
                    chk("m_bub_addr", fetch_addr, 15'h0);
                    chk("m_bub_instr", fetch_instr, NOP);
                end
                if (stall_i || !run_i) chk("m_no_issue", pmem_rd, 1'b0);
                else if (m_engaged)    chk("m_issue", pmem_rd, 1'b1);
                if (pmem_rd) begin
                    chk("m_paddr", pmem_addr, m_exp_pc);
                    m_exp_pc = m_exp_pc + 15'd1;
                end
            end
            m_engaged    = pmem_rd | (stall_i & m_engaged);
            m_prev_rd    = pmem_rd;
            m_prev_vld   = fetch_valid;
            m_prev_stall = stall_i;
        end
    end

    task automatic cyc(input logic run, input logic stall,
                       input logic redir, input logic [14:0] ra);
        run_i           = run;
        stall_i         = stall;
        redirect_i      = redir;
        redirect_addr_i = ra;
        @(negedge clk);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic see(input string nm, input logic [14:0] a);
        chk({nm, "_vld"}, fetch_valid, 1'b1);
        chk({nm, "_addr"}, fetch_addr, a);
        chk({nm, "_instr"}, fetch_instr, BASE + {17'd0, a});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1, 0, 0, 0); chk("A_rd", pmem_rd, 1'b0); nxt();
        cyc(1, 0, 0, 0);
        chk("B_rd", pmem_rd, 1'b1);
        chk("B_paddr", pmem_addr, 15'h0);
        chk("B_vld", fetch_valid, 1'b0);
        nxt();
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0); see("seq", 15'(i)); nxt();
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0); see("stall5", 15'h5);
            chk("stall5_rd", pmem_rd, 1'b0); nxt();
        end
        cyc(1, 0, 0, 0); see("rel5", 15'h5);
        chk("rel5_paddr", pmem_addr, 15'h6); nxt();
        cyc(1, 0, 0, 0); see("after6", 15'h6); nxt();
        cyc(1, 0, 0, 0); see("after7", 15'h7); nxt();
        cyc(1, 0, 1, 15'h100);
        chk("rd1_vld", fetch_valid, 1'b0);
        chk("rd1_instr", fetch_instr, NOP);
        chk("rd1_paddr", pmem_addr, 15'h100);
        chk("rd1_rd", pmem_rd, 1'b1);
        nxt();
        cyc(1, 0, 0, 0); see("tgt", 15'h100); nxt();
        cyc(1, 0, 0, 0); see("tgt1", 15'h101); nxt();
        cyc(1, 1, 0, 0); see("q", 15'h102); nxt();
        cyc(1, 1, 0, 0); see("r", 15'h102); nxt();
        cyc(1, 1, 1, 15'h100);
        chk("rd2_vld", fetch_valid, 1'b0);
        chk("rd2_paddr", pmem_addr, 15'h100);
        nxt();
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 0, 0); see("rdst", 15'h100); nxt();
        end
        cyc(1, 0, 0, 0); see("v", 15'h100);
        chk("v_paddr", pmem_addr, 15'h101); nxt();
        cyc(1, 0, 0, 0); see("w", 15'h101); nxt();
        cyc(0, 0, 0, 0); see("x", 15'h102);
        chk("x_rd", pmem_rd, 1'b0); nxt();
        cyc(0, 0, 0, 0); chk("y_vld", fetch_valid, 1'b0); nxt();
        cyc(1, 0, 0, 0); chk("z_rd", pmem_rd, 1'b0); nxt();
        cyc(1, 0, 0, 0); chk("aa_paddr", pmem_addr, 15'h103);
        chk("aa_rd", pmem_rd, 1'b1); nxt();
        cyc(1, 0, 0, 0); see("ab", 15'h103); nxt();
        cyc(1, 1, 0, 0); see("ac", 15'h104); nxt();
        cyc(1, 1, 0, 0); see("ad", 15'h104);
        #2 rst = 1'b0;
        #1;
        chk("arst_vld", fetch_valid, 1'b0);
        chk("arst_addr", fetch_addr, 15'h0);
        chk("arst_instr", fetch_instr, NOP);
        chk("arst_rd", pmem_rd, 1'b0);
        chk("arst_paddr", pmem_addr, 15'h0);
        nxt();
        cyc(1, 0, 0, 0); nxt();
        rst = 1'b1;
        cyc(1, 0, 0, 0); chk("A2_rd", pmem_rd, 1'b0); nxt();
        cyc(1, 0, 0, 0); chk("B2_paddr", pmem_addr, 15'h0); nxt();
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0); see("re", 15'(i)); nxt();
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0); see("re_st", 15'h5); nxt();
        end
        for (int i = 5; i < 10; i++) begin
            cyc(1, 0, 0, 0); see("re2", 15'(i)); nxt();
        end
        cyc(0, 0, 0, 0); see("p", 15'd10);
`ifdef FETCH_CTRL_PERF_EN
        chk("perf_fetched10", perf_fetched, 32'd10);
        chk("perf_stall3", perf_stall, 32'd3);
`endif
        nxt();
        chk("d2_rst_paddr", pmem_addr2, 15'h7FFE);
        chk("d2_rst_vld", fetch_valid2, 1'b0);
        rst2 = 1'b1;
        @(negedge clk); chk("d2_idle_rd", pmem_rd2, 1'b0); nxt();
        @(negedge clk); chk("d2_first_paddr", pmem_addr2, 15'h7FFE); nxt();
        for (int i = 0; i < 4; i++) begin
            logic [14:0] a;
            a = 15'h7FFE + 15'(i);
            @(negedge clk);
            chk("d2_vld", fetch_valid2, 1'b1);
            chk("d2_addr", fetch_addr2, a);
            chk("d2_instr", fetch_instr2, BASE + {17'd0, a});
            nxt();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
